// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_pkg
// Purpose  : Shared definitions for the AXI4-Lite seven-segment scanner:
//            AXI response codes, register byte offsets and the hex font.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // Register byte offsets
  localparam int REG_CTRL     = 'h00;
  localparam int REG_VALUE    = 'h04;
  localparam int REG_DP       = 'h08;
  localparam int REG_DIV      = 'h0C;
  localparam int REG_BRIGHT   = 'h10;
  localparam int REG_RAW_BASE = 'h20;

  // Active-high font, bit order {g,f,e,d,c,b,a}; entry 15 is leftmost
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic logic [6:0] hex_font(input logic [3:0] nibble);
    return HEX_FONT[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_axil_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_axil_scan_if
// Purpose  : AXI4-Lite bus bundle (32-bit data) between the interconnect
//            master and the seven-segment scanner slave.
// Ports    : AW/W/B write channels, AR/R read channels; master and slave
//            modports give the direction from each side.
// Revision : 1.0 - initial release
// ============================================================================
interface sevenseg_axil_scan_if #(
  parameter int ADDR_W = 6
) ();

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface
`default_nettype wire

// File: rtl/sevenseg_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_hex_decoder
// Purpose  : Combinational hex nibble to seven-segment pattern.
// Ports    : nibble in  4  hex digit
//            seg    out 7  active-high segments {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_hex_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_font(nibble);

endmodule
`default_nettype wire

// File: rtl/sevenseg_axil_scan.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_axil_scan
// Purpose  : AXI4-Lite seven-segment controller. Register file for value,
//            decimal points, raw segments and control; time-multiplexed
//            digit scan with programmable slot length, deghost gap, PWM
//            brightness, per-digit blanking and hex/raw modes.
// Ports    : ACLK     in  1         clock
//            ARESETN  in  1         asynchronous active-low reset
//            axi      slave         AXI4-Lite register port
//            an       out N_DIGITS  digit enables (polarity AN_ACTIVE_LOW)
//            seg      out 7         segments {g..a} (polarity SEG_ACTIVE_LOW)
//            dp       out 1         decimal point (polarity SEG_ACTIVE_LOW)
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_axil_scan
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int ADDR_W         = 6,
  parameter int DIV_W          = 20,
  parameter int DEFAULT_DIV    = 100000,
  parameter int GAP_CYC        = 4,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  sevenseg_axil_scan_if.slave  axi,
  output logic [N_DIGITS-1:0]  an,
  output logic [6:0]           seg,
  output logic                 dp
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(REG_CTRL / 4);
  localparam logic [WORD_W-1:0] W_VALUE  = WORD_W'(REG_VALUE / 4);
  localparam logic [WORD_W-1:0] W_DP     = WORD_W'(REG_DP / 4);
  localparam logic [WORD_W-1:0] W_DIV    = WORD_W'(REG_DIV / 4);
  localparam logic [WORD_W-1:0] W_BRIGHT = WORD_W'(REG_BRIGHT / 4);
  localparam logic [WORD_W-1:0] W_RAW0   = WORD_W'(REG_RAW_BASE / 4);

  // --------------------------------------------------------------------------
  // Register file state
  // --------------------------------------------------------------------------
  logic                     en;
  logic                     raw_mode;
  logic [N_DIGITS-1:0]      blank;
  logic [N_DIGITS-1:0][3:0] value_nib;
  logic [N_DIGITS-1:0]      dp_bits;
  logic [DIV_W-1:0]         div;
  logic [7:0]               bright;
  logic [N_DIGITS-1:0][7:0] raw_seg;

  // AXI handshake state
  logic        awready;
  logic        bvalid;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;

  // Read view of one register word; unmapped words and unused bits read 0
  function automatic logic [31:0] reg_read(input logic [WORD_W-1:0] word);
    logic [31:0] rd;
    rd = '0;
    if (word == W_CTRL) begin
      rd[0] = en;
      rd[1] = raw_mode;
      for (int d = 0; d < N_DIGITS; d++) rd[8+d] = blank[d];
    end
    if (word == W_VALUE) begin
      for (int d = 0; d < N_DIGITS; d++) rd[4*d +: 4] = value_nib[d];
    end
    if (word == W_DP)     rd[N_DIGITS-1:0] = dp_bits;
    if (word == W_DIV)    rd[DIV_W-1:0]    = div;
    if (word == W_BRIGHT) rd[7:0]          = bright;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (word == W_RAW0 + WORD_W'(d)) rd[7:0] = raw_seg[d];
    end
    return rd;
  endfunction

  // --------------------------------------------------------------------------
  // AXI4-Lite handshakes
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic              wr_fire;
  logic              rd_fire;
  logic [31:0]       wr_cur;
  logic [31:0]       wr_new;
  logic [31:0]       strb_mask;

  assign wr_word = axi.awaddr[ADDR_W-1:2];
  assign rd_word = axi.araddr[ADDR_W-1:2];
  // WREADY mirrors AWREADY, and AWREADY only rises with both valids present
  assign wr_fire = awready & axi.awvalid & axi.wvalid;
  assign rd_fire = arready & axi.arvalid;

  // Byte-lane merge against the current readable contents of the target
  always_comb begin
    wr_cur = reg_read(wr_word);
    for (int b = 0; b < 4; b++) strb_mask[8*b +: 8] = {8{axi.wstrb[b]}};
    wr_new = (wr_cur & ~strb_mask) | (axi.wdata & strb_mask);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready <= 1'b0;
      bvalid  <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      // One-cycle ready pulses; the !ready term stops back-to-back accepts
      awready <= axi.awvalid & axi.wvalid & ~bvalid & ~awready;
      if (wr_fire)          bvalid <= 1'b1;
      else if (axi.bready)  bvalid <= 1'b0;

      arready <= axi.arvalid & ~rvalid & ~arready;
      if (rd_fire) begin
        rvalid <= 1'b1;
        rdata  <= reg_read(rd_word);   // pre-write value on a shared edge
      end else if (axi.rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign axi.awready = awready;
  assign axi.wready  = awready;
  assign axi.bresp   = RESP_OKAY;
  assign axi.bvalid  = bvalid;
  assign axi.arready = arready;
  assign axi.rdata   = rdata;
  assign axi.rresp   = RESP_OKAY;
  assign axi.rvalid  = rvalid;

  // Register updates
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en        <= 1'b0;
      raw_mode  <= 1'b0;
      blank     <= '0;
      value_nib <= '0;
      dp_bits   <= '0;
      div       <= DIV_W'(DEFAULT_DIV);
      bright    <= 8'hFF;
      raw_seg   <= '0;
    end else if (wr_fire) begin
      if (wr_word == W_CTRL) begin
        en       <= wr_new[0];
        raw_mode <= wr_new[1];
        blank    <= wr_new[8 +: N_DIGITS];
      end
      if (wr_word == W_VALUE) begin
        for (int d = 0; d < N_DIGITS; d++) value_nib[d] <= wr_new[4*d +: 4];
      end
      if (wr_word == W_DP)     dp_bits <= wr_new[N_DIGITS-1:0];
      if (wr_word == W_DIV)    div     <= wr_new[DIV_W-1:0];
      if (wr_word == W_BRIGHT) bright  <= wr_new[7:0];
      for (int d = 0; d < N_DIGITS; d++) begin
        if (wr_word == W_RAW0 + WORD_W'(d)) raw_seg[d] <= wr_new[7:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan prescaler, digit index and PWM counter
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       pwm;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt <= '0;
      idx <= '0;
    end else if (!en) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt >= div) begin
      // >= rather than == so a DIV reduced mid-slot ends the slot at once
      cnt <= '0;
      idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) pwm <= '0;
    else          pwm <= pwm + 8'd1;
  end

  // Deghost gap: anodes stay off for the first GAP_CYC cycles of a slot
  logic gap_ok;
  generate
    if (GAP_CYC == 0) begin : g_no_gap
      assign gap_ok = 1'b1;
    end else begin : g_gap
      assign gap_ok = (cnt >= DIV_W'(GAP_CYC));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output stage (active-high internally, polarity applied at the flops)
  // --------------------------------------------------------------------------
  logic                digit_on;
  logic [6:0]          font_seg;
  logic [N_DIGITS-1:0] an_next;
  logic [6:0]          seg_next;
  logic                dp_next;

  sevenseg_hex_decoder u_hex (
    .nibble (value_nib[idx]),
    .seg    (font_seg)
  );

  always_comb begin
    // BRIGHT=0xFF is full-on; otherwise pwm 0xFF would leave one dark cycle
    digit_on = en && !blank[idx] && gap_ok && ((bright == 8'hFF) || (pwm < bright));
    an_next  = digit_on ? (N_DIGITS'(1) << idx) : '0;
    seg_next = '0;
    dp_next  = 1'b0;
    if (digit_on) begin
      if (raw_mode) begin
        seg_next = raw_seg[idx][6:0];
        dp_next  = raw_seg[idx][7];
      end else begin
        seg_next = font_seg;
        dp_next  = dp_bits[idx];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      an  <= {N_DIGITS{AN_ACTIVE_LOW}};
      seg <= {7{SEG_ACTIVE_LOW}};
      dp  <= SEG_ACTIVE_LOW;
    end else begin
      an  <= an_next ^ {N_DIGITS{AN_ACTIVE_LOW}};
      seg <= seg_next ^ {7{SEG_ACTIVE_LOW}};
      dp  <= dp_next ^ SEG_ACTIVE_LOW;
    end
  end

  // Address LSBs and merged bits beyond the implemented fields are don't-care
  logic unused_bits;
  assign unused_bits = ^{axi.awaddr[1:0], axi.araddr[1:0], wr_new};

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_axil_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_axil_scan
// Purpose  : Directed self-checking bench for sevenseg_axil_scan (4 digits,
//            no deghost gap, active-low anodes and segments).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_axil_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  sevenseg_axil_scan_if #(.ADDR_W(6)) axi ();

  sevenseg_axil_scan #(
    .N_DIGITS       (4),
    .ADDR_W         (6),
    .DIV_W          (20),
    .DEFAULT_DIV    (100000),
    .GAP_CYC        (0),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .axi     (axi),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input string tag, input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    @(negedge clk);
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.awready && n < 20);
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 0;
    while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, 32'(axi.bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(axi.bresp), 32'd0);
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [5:0] a, input logic [31:0] exp);
    int n;
    logic [31:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    axi.araddr = a; axi.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 20);
    @(negedge clk);
    axi.arvalid = 1'b0;
    n = 0;
    while (!axi.rvalid && n < 20) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, 32'(axi.rvalid), 32'd1);
    e = exp_q.pop_front();
    check(tag, axi.rdata, e);
    check({tag, "_rresp"}, 32'(axi.rresp), 32'd0);
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
  endtask

  task automatic wait_an(input string tag, input logic [3:0] target, input int bound);
    int n;
    n = 0;
    while (an !== target && n < bound) begin @(negedge clk); n++; end
    check({tag, "_reach"}, 32'(an === target), 32'd1);
  endtask

  initial begin
    int n;
    int c0, c1;
    logic [3:0] e;
    logic [31:0] e32;

    rst_n = 1'b0;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
    axi.wvalid = 1'b0; axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_axi", 32'({axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid}), 32'd0);
    rst_n = 1'b1;

    axi_read("rst_ctrl",   6'h00, 32'h0);
    axi_read("rst_value",  6'h04, 32'h0);
    axi_read("rst_dp",     6'h08, 32'h0);
    axi_read("rst_div",    6'h0C, 32'd100000);
    axi_read("rst_bright", 6'h10, 32'hFF);
    axi_read("rst_raw0",   6'h20, 32'h0);

    // Simple write/read-back
    for (int i = 0; i < 5; i++) axi_write("wr_seq", 6'(4*i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 5; i++) axi_read("rd_seq", 6'(4*i), 32'(i + 1));
    axi_read("rd_unmapped14", 6'h14, 32'h0);

    // Field masking
    axi_write("wr_ctrl_all", 6'h00, 32'hFFFF_FFFF, 4'hF);
    axi_read("mask_ctrl", 6'h00, 32'h0000_0F03);
    axi_write("wr_dp_all", 6'h08, 32'hFFFF_FFFF, 4'hF);
    axi_read("mask_dp", 6'h08, 32'h0000_000F);
    axi_write("wr_div_all", 6'h0C, 32'hFFFF_FFFF, 4'hF);
    axi_read("mask_div", 6'h0C, 32'h000F_FFFF);
    axi_write("wr_value_all", 6'h04, 32'hFFFF_FFFF, 4'hF);
    axi_read("mask_value", 6'h04, 32'h0000_FFFF);
    axi_write("wr_raw1", 6'h24, 32'hFFFF_FFFF, 4'hF);
    axi_read("mask_raw1", 6'h24, 32'h0000_00FF);
    axi_write("wr_raw4", 6'h30, 32'hFFFF_FFFF, 4'hF);
    axi_read("rd_raw4_unmapped", 6'h30, 32'h0);

    // Byte strobes
    axi_write("wr_value_clr", 6'h04, 32'h0, 4'hF);
    axi_write("wr_value_strb", 6'h04, 32'h0000_FFFF, 4'b0010);
    axi_read("strb_value", 6'h04, 32'h0000_FF00);

    // Read and write to the same register on one edge
    axi_write("wr_bright5a", 6'h10, 32'h5A, 4'hF);
    exp_q.push_back(32'h5A);
    @(negedge clk);
    axi.awaddr = 6'h10; axi.wdata = 32'h11; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.araddr = 6'h10; axi.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(axi.awready && axi.arready) && n < 20);
    check("same_edge_ready", 32'(axi.awready && axi.arready), 32'd1);
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    n = 0;
    while (!(axi.bvalid && axi.rvalid) && n < 20) begin @(negedge clk); n++; end
    e32 = exp_q.pop_front();
    check("same_edge_rdata", axi.rdata, e32);
    axi.bready = 1'b1; axi.rready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0; axi.rready = 1'b0;
    axi_read("same_edge_after", 6'h10, 32'h11);

    // Scan walk, DIV=3
    axi_write("cfg_ctrl0", 6'h00, 32'h0, 4'hF);
    axi_write("cfg_bright", 6'h10, 32'hFF, 4'hF);
    axi_write("cfg_dp0", 6'h08, 32'h0, 4'hF);
    axi_write("cfg_value8", 6'h04, 32'h8, 4'hF);
    axi_write("cfg_div3", 6'h0C, 32'h3, 4'hF);
    axi_write("cfg_en", 6'h00, 32'h1, 4'hF);
    wait_an("sync_d3", 4'b0111, 100);
    wait_an("sync_d0", 4'b1110, 10);
    for (int j = 0; j < 20; j++) begin
      e = ~(4'b0001 << ((j / 4) % 4));
      check("scan_walk", 32'(an), 32'(e));
      @(negedge clk);
    end

    // Hex font and decimal point
    wait_an("hex_d0", 4'b1110, 20);
    check("hex8_seg", 32'(seg), 32'h00);
    check("hex8_dp", 32'(dp), 32'd1);
    wait_an("hex_d1", 4'b1101, 20);
    check("hex0_seg", 32'(seg), 32'b1000000);
    axi_write("cfg_dp1", 6'h08, 32'h1, 4'hF);
    wait_an("dp_d1", 4'b1101, 20);
    wait_an("dp_d0", 4'b1110, 20);
    check("dp_on", 32'(dp), 32'd0);

    // Raw mode
    axi_write("cfg_raw0", 6'h20, 32'h06, 4'hF);
    axi_write("cfg_rawmode", 6'h00, 32'h3, 4'hF);
    wait_an("raw_d1", 4'b1101, 20);
    wait_an("raw_d0", 4'b1110, 20);
    check("raw_seg", 32'(seg), 32'b1111001);
    check("raw_dp", 32'(dp), 32'd1);
    axi_write("cfg_hexmode", 6'h00, 32'h1, 4'hF);

    // Brightness
    axi_write("cfg_bright0", 6'h10, 32'h00, 4'hF);
    repeat (4) @(negedge clk);
    c0 = 0;
    for (int k = 0; k < 256; k++) begin
      if (an != 4'hF) c0++;
      @(negedge clk);
    end
    check("bright0_active", 32'(c0), 32'd0);
    axi_write("cfg_bright80", 6'h10, 32'h80, 4'hF);
    repeat (4) @(negedge clk);
    c0 = 0;
    for (int k = 0; k < 256; k++) begin
      if (an != 4'hF) c0++;
      @(negedge clk);
    end
    check("bright80_active", 32'(c0), 32'd128);

    // Blanking digit 1
    axi_write("cfg_brightff", 6'h10, 32'hFF, 4'hF);
    axi_write("cfg_blank1", 6'h00, 32'h201, 4'hF);
    repeat (4) @(negedge clk);
    c0 = 0; c1 = 0;
    for (int k = 0; k < 64; k++) begin
      if (an[0] == 1'b0) c0++;
      if (an[1] == 1'b0) c1++;
      @(negedge clk);
    end
    check("blank_d1", 32'(c1), 32'd0);
    check("blank_d0", 32'(c0), 32'd16);

    // Lowering DIV mid-slot
    axi_write("cfg_noblank", 6'h00, 32'h1, 4'hF);
    axi_write("cfg_div1000", 6'h0C, 32'd1000, 4'hF);
    wait_an("div_d1", 4'b1101, 5000);
    repeat (20) @(negedge clk);
    check("div_long_slot", 32'(an), 32'b1101);
    axi_write("cfg_div2", 6'h0C, 32'd2, 4'hF);
    wait_an("div_short", 4'b1011, 10);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dp", 32'(dp), 32'd1);
    check("arst_axi", 32'({axi.bvalid, axi.rvalid, axi.awready, axi.arready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read("arst_ctrl", 6'h00, 32'h0);
    axi_read("arst_div", 6'h0C, 32'd100000);
    axi_read("arst_value", 6'h04, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
